// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the 3-bit opcode encoding used by the control unit and the
// two-state FSM encoding of the iterative engine.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;  // result = data2
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;  // data1 - data2
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;  // low half of unsigned product
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift / multiply engine for alu_seq.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : load operands and the iteration counter
//   op           : OP_SLL, OP_SRA or OP_MUL (sampled on start)
//   a, b         : operands (b is the multiplier for OP_MUL)
//   amt          : shift amount (sampled on start)
//   step         : advance one bit position this clock
//   done         : combinational, high on the step that finishes the op
//   result       : value after the current step; valid while done is high
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SH_W-1:0]   amt,
  input  logic              step,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  // One extra bit so the counter can hold DATA_W for a multiply.
  localparam int CNT_W = SH_W + 1;

  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [DATA_W-1:0] acc_next, mcand_next, mplier_next;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    case (op_q)
      OP_SLL: acc_next = acc << 1;
      OP_SRA: acc_next = {acc[DATA_W-1], acc[DATA_W-1:1]};
      OP_MUL: begin
        // Shift-add: partial products beyond DATA_W fall off the top of mcand.
        acc_next    = acc + (mplier[0] ? mcand : '0);
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
      end
      default: acc_next = acc;
    endcase
  end

  assign done   = step && (cnt == CNT_W'(1));
  assign result = acc_next;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_FWD;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      op_q <= op;
      if (op == OP_MUL) begin
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        cnt    <= CNT_W'(DATA_W);
      end else begin
        acc    <= a;
        mcand  <= '0;
        mplier <= '0;
        cnt    <= {1'b0, amt};
      end
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU between the register file read ports and the
// write-back mux. FWD/ADD/AND/OR/SUB (and shifts by zero) finish on the
// accept edge; SLL/SRA/MUL run in alu_iter_unit while the FSM is BUSY.
// Optional macro ALU_FLAGS_EN adds registered CARRY and OVF outputs.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (in_ready = state is IDLE)
//   select              : opcode (see alu_pkg)
//   data1, data2        : operands; shift amount is data2[SH_W-1:0]
//   result, zero        : registered result and result==0 flag
//   out_valid           : one-cycle strobe marking a new result
//   carry, ovf          : (ALU_FLAGS_EN only) ADD/SUB flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        select,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              out_valid
`ifdef ALU_FLAGS_EN
  , output logic            carry
  , output logic            ovf
`endif
);

  state_t            state;
  logic              accept, iter_op, iter_done;
  logic [SH_W-1:0]   amt;
  logic [DATA_W-1:0] sc_result, iter_result;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign amt      = data2[SH_W-1:0];
  // A shift by zero has nothing to iterate and completes like a simple op.
  assign iter_op  = (select == OP_MUL) ||
                    (((select == OP_SLL) || (select == OP_SRA)) && (amt != '0));

  always_comb begin
    sc_result = data2;
    case (select)
      OP_FWD:  sc_result = data2;
      OP_ADD:  sc_result = data1 + data2;
      OP_AND:  sc_result = data1 & data2;
      OP_OR:   sc_result = data1 | data2;
      OP_SUB:  sc_result = data1 - data2;
      default: sc_result = data1;  // SLL/SRA by zero
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [DATA_W:0] add_full, sub_full;
  logic            sc_carry, sc_ovf;

  always_comb begin
    add_full = {1'b0, data1} + {1'b0, data2};
    sub_full = {1'b0, data1} + {1'b0, ~data2} + (DATA_W+1)'(1);
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    if (select == OP_ADD) begin
      sc_carry = add_full[DATA_W];
      sc_ovf   = (data1[DATA_W-1] == data2[DATA_W-1]) &&
                 (add_full[DATA_W-1] != data1[DATA_W-1]);
    end else if (select == OP_SUB) begin
      sc_carry = sub_full[DATA_W];  // set when no borrow
      sc_ovf   = (data1[DATA_W-1] != data2[DATA_W-1]) &&
                 (sub_full[DATA_W-1] != data1[DATA_W-1]);
    end
  end
`endif

  alu_iter_unit #(
    .DATA_W (DATA_W),
    .SH_W   (SH_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && iter_op),
    .op     (select),
    .a      (data1),
    .b      (data2),
    .amt    (amt),
    .step   (state == ST_BUSY),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
      carry     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (iter_op) begin
              state <= ST_BUSY;
            end else begin
              result    <= sc_result;
              zero      <= (sc_result == '0);
              out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
              carry     <= sc_carry;
              ovf       <= sc_ovf;
`endif
            end
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            state     <= ST_IDLE;
            result    <= iter_result;
            zero      <= (iter_result == '0);
            out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
            carry     <= 1'b0;
            ovf       <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DATA_W = 8).
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] select;
  logic [7:0] data1, data2;
  logic [7:0] result;
  logic       zero;
  logic       out_valid;
`ifdef ALU_FLAGS_EN
  logic       carry, ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .data1     (data1),
    .data2     (data2),
    .result    (result),
    .zero      (zero),
    .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
    , .carry   (carry)
    , .ovf     (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] d1, input logic [7:0] d2);
    in_valid = 1'b1;
    select   = sel;
    data1    = d1;
    data2    = d2;
  endtask

  // Issues one op, then measures clocks until out_valid and the number of
  // in_ready-low cycles. With junk set, a different request and different
  // operands are presented while the ALU is busy; they must be ignored.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] exp, input int lat,
                        input bit junk);
    int  k    = 0;
    int  low  = 0;
    bit  seen = 1'b0;
    @(negedge clk);
    drive(sel, d1, d2);
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (out_valid) seen = 1'b1;
      else begin
        if (!in_ready) low++;
        if (junk) drive(OP_FWD, 8'h33, 8'hEE);
        else      in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, k, lat);
    check({tag, "_result"}, result, exp);
    check({tag, "_zero"}, zero, (exp == 8'h00));
    check({tag, "_ready_low"}, low, lat - 1);
    @(negedge clk);
    check({tag, "_strobe_once"}, out_valid, 1'b0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [7:0] bb_exp [5];
    logic [2:0] bb_op  [5];
    int         stray;

    reset    = 1'b1;
    in_valid = 1'b0;
    select   = OP_FWD;
    data1    = '0;
    data2    = '0;
    #1;
    check("rst_result", result, 8'h00);
    check("rst_zero", zero, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back single-cycle ops on 0x55 / 0x0F.
    bb_op  = '{OP_FWD, OP_ADD, OP_AND, OP_OR, OP_SUB};
    bb_exp = '{8'h0F, 8'h64, 8'h05, 8'h5F, 8'h46};
    @(negedge clk);
    drive(bb_op[0], 8'h55, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_valid", i), out_valid, 1'b1);
      check($sformatf("b2b%0d_result", i), result, bb_exp[i]);
      check($sformatf("b2b%0d_ready", i), in_ready, 1'b1);
      if (i < 4) drive(bb_op[i+1], 8'h55, 8'h0F);
      else       in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_strobe_end", out_valid, 1'b0);

    run_op("mul_0d_0b", OP_MUL, 8'h0D, 8'h0B, 8'h8F, 9, 1'b1);
    run_op("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 8'h01, 9, 1'b0);
    run_op("sll_55_3",  OP_SLL, 8'h55, 8'h03, 8'hA8, 4, 1'b1);
    run_op("sra_80_7",  OP_SRA, 8'h80, 8'h07, 8'hFF, 8, 1'b0);
    run_op("sll_55_0",  OP_SLL, 8'h55, 8'h00, 8'h55, 1, 1'b0);
    run_op("sll_upper", OP_SLL, 8'h55, 8'hFB, 8'hA8, 4, 1'b0);
    run_op("sll_01_7",  OP_SLL, 8'h01, 8'h07, 8'h80, 8, 1'b0);
    run_op("sra_40_2",  OP_SRA, 8'h40, 8'h02, 8'h10, 3, 1'b0);
    run_op("sub_zero",  OP_SUB, 8'h2A, 8'h2A, 8'h00, 1, 1'b0);
`ifdef ALU_FLAGS_EN
    check("sub_zero_carry", carry, 1'b1);
    check("sub_zero_ovf", ovf, 1'b0);
`endif
    run_op("add_64_64", OP_ADD, 8'h64, 8'h64, 8'hC8, 1, 1'b0);
`ifdef ALU_FLAGS_EN
    check("add_64_carry", carry, 1'b0);
    check("add_64_ovf", ovf, 1'b1);
`endif

    // Reset in the middle of a multiply.
    @(negedge clk);
    drive(OP_MUL, 8'h0D, 8'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_zero", zero, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("mid_rst_no_strobe", stray, 0);
    drive(OP_ADD, 8'h01, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_add_valid", out_valid, 1'b1);
    check("post_rst_add_result", result, 8'h02);
    check("post_rst_add_zero", zero, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
